arbitro_rr_2x1_4b: RTL and testbench
====================================

Name: arbitro_rr_2x1_4b

Overview:
Round-robin arbiter and sequencer for the registered 2x1 4-bit mux datapath. Two requester lanes push valid-tagged words into per-lane FIFOs. The block decides each cycle which lane drives the shared output register and drives the selector accordingly. A burst limit bounds the number of consecutive grants one lane can receive.

Parameters:
DATA_W, 4, data width per lane
DEPTH, 4, entries per lane FIFO (power of 2, >=2)
MAX_BURST, 4, max consecutive grants to one lane while the other lane is non-empty (>=1)

Ports:
clk  input  1  single clock, all state on posedge
reset_L  input  1  asynchronous active-low reset
valid_in0  input  1  lane 0 push request
data_in0  input  DATA_W  lane 0 data
ready_out0  output  1  lane 0 FIFO not full
valid_in1  input  1  lane 1 push request
data_in1  input  DATA_W  lane 1 data
ready_out1  output  1  lane 1 FIFO not full
ready_in  input  1  downstream accepts data_out
valid_out  output  1  data_out holds a valid word
data_out  output  DATA_W  granted word (registered)
selector  output  1  lane that sourced data_out

Behaviour:
- Reset (async, reset_L=0): FIFOs emptied, all counts=0, valid_out=0, data_out=0, selector=0, state=IDLE, last_grant=1, burst_cnt=0. Reset mid-operation discards all stored words. No stale data appears after release.
- ready_outN = (countN != DEPTH). It depends only on the registered count, not on same-cycle pop.
- Push lane N when valid_inN && ready_outN. valid_inN while full: the word is dropped and the count is unchanged.
- Output advance: adv = !valid_out || ready_in.
  - On adv with a grant: pop the lane head, data_out<=head, selector<=lane, valid_out<=1.
  - On adv with no grant: valid_out<=0; data_out and selector hold.
  - No adv: data_out, selector and valid_out are held. No pop.
- FSM states: IDLE, SERV0, SERV1. It is evaluated only on adv.
  - IDLE: if both lanes are non-empty, grant lane != last_grant. If one lane is non-empty, grant it. If neither, stay in IDLE.
  - SERVk: continue lane k if non-empty and (burst_cnt < MAX_BURST or other lane empty). Otherwise switch to the other lane if it is non-empty. Otherwise go to IDLE.
  - Any grant updates last_grant.
- burst_cnt: set to 1 on a lane switch or a grant from IDLE. Increments on a repeated grant and saturates at MAX_BURST.
- Simultaneous push and pop on the same lane: count unchanged, both operations are performed.
- Latency: a word pushed into an empty lane while the output is free is seen as valid_out=1 two clock edges after the push edge.
- Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide.

Optional Feature:
STATS_EN
- Defined: adds outputs grant_cnt0 and grant_cnt1, each 8-bit. Each counts words delivered from its lane (increment on pop), wraps 255->0, and resets to 0.
- Undefined: these ports and counters are absent. Remaining behaviour is identical.

Decomposition:
- Shared package arb_pkg:
  - state encodings ST_IDLE=2'b00, ST_SERV0=2'b01, ST_SERV1=2'b10
  - lane IDs LANE0=1'b0, LANE1=1'b1
  - default DATA_W
- Sub-module fifo_sinc_4b: synchronous FIFO with push, pop, data, count, async active-low reset. It is instantiated once per lane. Arbitration, FSM, burst counter and output register live in the top module.

Test Plan:
- Reset: hold reset_L=0 -> valid_out=0, data_out=0, selector=0, ready_out0=ready_out1=1. Release with no pushes -> valid_out stays 0.
- Single lane: push 4'h1, 4'h2, 4'h3 on lane 0 in consecutive cycles, ready_in=1 -> data_out 1, 2, 3 on consecutive cycles, selector=0, first valid_out two edges after the first push.
- Burst fairness: MAX_BURST=2, ready_in=0. Fill lane 0 with A0..A3 and lane 1 with B0..B3, then set ready_in=1 -> output order A0 A1 B0 B1 A2 A3 B2 B3, selector 0,0,1,1,0,0,1,1.
- Backpressure: with valid_out=1 and data_out=4'h7, hold ready_in=0 for 3 cycles while pushing -> data_out, selector and valid_out stable, no pop, FIFO counts only increase.
- Full: lane 1 count=4, push 4'hF -> ready_out1=0, word dropped. Later drain shows exactly 4 words, no 4'hF.
- Reset mid-operation: both FIFOs holding data and valid_out=1, pulse reset_L=0 -> outputs return to reset values immediately. After release, valid_out=0 until a new push.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encodings, lane IDs and default width for the 2x1 round-robin arbiter
package arb_pkg;

    localparam int ARB_DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERV0 = 2'b01,
        ST_SERV1 = 2'b10
    } arb_state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/fifo_sinc_4b.sv
// rtl/fifo_sinc_4b.sv - per-lane synchronous FIFO with push/pop, head data and occupancy count
module fifo_sinc_4b
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Push is refused on the registered full state even if a pop happens this cycle.
    assign do_push   = push && (count_q != CNT_W'(DEPTH));
    assign do_pop    = pop && (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/arbitro_rr_2x1_4b.sv
// rtl/arbitro_rr_2x1_4b.sv - burst-limited round-robin arbiter feeding a registered 2x1 output; STATS_EN adds per-lane grant counters
module arbitro_rr_2x1_4b
    import arb_pkg::*;
#(
    parameter int DATA_W    = ARB_DATA_W,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready_out0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready_out1,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
`ifdef STATS_EN
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1,
`endif
    output logic              selector
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0]   count0, count1;
    logic [DATA_W-1:0]  head0, head1;
    logic               ne0, ne1;
    logic               adv;
    logic               grant_valid;
    logic               grant_lane;
    logic               pop0, pop1;

    arb_state_e         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               valid_out_q, valid_out_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               selector_q, selector_d;

    fifo_sinc_4b #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (reset_L),
        .push      (valid_in0),
        .push_data (data_in0),
        .pop       (pop0),
        .head_data (head0),
        .count     (count0)
    );

    fifo_sinc_4b #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (reset_L),
        .push      (valid_in1),
        .push_data (data_in1),
        .pop       (pop1),
        .head_data (head1),
        .count     (count1)
    );

    assign ne0        = (count0 != '0);
    assign ne1        = (count1 != '0);
    assign ready_out0 = (count0 != CNT_W'(DEPTH));
    assign ready_out1 = (count1 != CNT_W'(DEPTH));
    assign adv        = !valid_out_q || ready_in;
    assign pop0       = adv && grant_valid && (grant_lane == LANE0);
    assign pop1       = adv && grant_valid && (grant_lane == LANE1);

    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = LANE0;
        case (state_q)
            ST_IDLE: begin
                if (ne0 && ne1) begin
                    grant_valid = 1'b1;
                    grant_lane  = ~last_grant_q;
                end else if (ne0 || ne1) begin
                    grant_valid = 1'b1;
                    grant_lane  = ne1;
                end
            end
            // A saturated burst only yields when the other lane actually has work.
            ST_SERV0: begin
                if (ne0 && ((burst_q < BURST_W'(MAX_BURST)) || !ne1)) begin
                    grant_valid = 1'b1;
                    grant_lane  = LANE0;
                end else if (ne1) begin
                    grant_valid = 1'b1;
                    grant_lane  = LANE1;
                end
            end
            ST_SERV1: begin
                if (ne1 && ((burst_q < BURST_W'(MAX_BURST)) || !ne0)) begin
                    grant_valid = 1'b1;
                    grant_lane  = LANE1;
                end else if (ne0) begin
                    grant_valid = 1'b1;
                    grant_lane  = LANE0;
                end
            end
            default: begin
                grant_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        valid_out_d  = valid_out_q;
        data_out_d   = data_out_q;
        selector_d   = selector_q;
        if (adv) begin
            if (grant_valid) begin
                valid_out_d  = 1'b1;
                data_out_d   = (grant_lane == LANE1) ? head1 : head0;
                selector_d   = grant_lane;
                last_grant_d = grant_lane;
                state_d      = (grant_lane == LANE1) ? ST_SERV1 : ST_SERV0;
                if ((state_q == ST_SERV0 && grant_lane == LANE0) ||
                    (state_q == ST_SERV1 && grant_lane == LANE1)) begin
                    if (burst_q != BURST_W'(MAX_BURST)) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else begin
                    burst_d = BURST_W'(1);
                end
            end else begin
                valid_out_d = 1'b0;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LANE1;
            burst_q      <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            selector_q   <= LANE0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            selector_q   <= selector_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign selector  = selector_q;

`ifdef STATS_EN
    logic [7:0] grant_cnt0_q, grant_cnt0_d;
    logic [7:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q + {7'd0, pop0};
        grant_cnt1_d = grant_cnt1_q + {7'd0, pop1};
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_arbitro_rr_2x1_4b.sv
// tb/tb_arbitro_rr_2x1_4b.sv - directed bench with a queue-level arbitration model and literal spot checks
module tb_arbitro_rr_2x1_4b;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXB  = 2;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          valid_in0 = 1'b0, valid_in1 = 1'b0;
    logic [DW-1:0] data_in0 = '0, data_in1 = '0;
    logic          ready_in = 1'b0;
    logic          ready_out0, ready_out1;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          selector;
`ifdef STATS_EN
    logic [7:0]    grant_cnt0, grant_cnt1;
`endif

    arbitro_rr_2x1_4b #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in0  (valid_in0),
        .data_in0   (data_in0),
        .ready_out0 (ready_out0),
        .valid_in1  (valid_in1),
        .data_in1   (data_in1),
        .ready_out1 (ready_out1),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
`ifdef STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .selector   (selector)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: two word queues plus "who is being served and for how long".
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sel;
    int            m_serving, m_streak, m_last, pick;
    bit            acc0, acc1, ne0, ne1;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mq0.delete();
            mq1.delete();
            m_valid   = 1'b0;
            m_data    = '0;
            m_sel     = 1'b0;
            m_serving = -1;
            m_streak  = 0;
            m_last    = 1;
        end else begin
            ne0  = mq0.size() > 0;
            ne1  = mq1.size() > 0;
            acc0 = valid_in0 && (mq0.size() < DEPTH);
            acc1 = valid_in1 && (mq1.size() < DEPTH);
            pick = -1;
            if (!m_valid || ready_in) begin
                if (ne0 && ne1) begin
                    if (m_serving < 0)        pick = 1 - m_last;
                    else if (m_streak < MAXB) pick = m_serving;
                    else                      pick = 1 - m_serving;
                end else if (ne0) pick = 0;
                else if (ne1)     pick = 1;
                if (pick >= 0) begin
                    m_streak  = (pick == m_serving) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
                    m_serving = pick;
                    m_last    = pick;
                    m_valid   = 1'b1;
                    m_sel     = pick[0];
                    m_data    = (pick == 1) ? mq1.pop_front() : mq0.pop_front();
                end else begin
                    m_valid   = 1'b0;
                    m_serving = -1;
                end
            end
            if (acc0) mq0.push_back(data_in0);
            if (acc1) mq1.push_back(data_in1);
        end
    end

    always @(negedge clk) begin
        check("model_valid_out", valid_out, m_valid);
        check("model_data_out", data_out, m_data);
        check("model_selector", selector, m_sel);
        check("model_ready_out0", ready_out0, mq0.size() != DEPTH);
        check("model_ready_out1", ready_out1, mq1.size() != DEPTH);
    end

    logic [DW-1:0] log_d[$];
    logic          log_s[$];

    always @(negedge clk) begin
        if (reset_L && valid_out && ready_in) begin
            log_d.push_back(data_out);
            log_s.push_back(selector);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_d[8];
    logic          exp_s[8];
    int            n1;

    initial begin
        // Reset
        step();
        step();
        @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_selector", selector, 0);
        check("rst_ready_out0", ready_out0, 1);
        check("rst_ready_out1", ready_out1, 1);
        step();
        reset_L = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("idle_valid_out", valid_out, 0);

        // Single lane, latency
        step();
        log_d.delete(); log_s.delete();
        ready_in = 1'b1;
        valid_in0 = 1'b1; data_in0 = 4'h1;
        step();
        data_in0 = 4'h2;
        @(negedge clk);
        check("lat_after_push_edge", valid_out, 0);
        step();
        data_in0 = 4'h3;
        @(negedge clk);
        check("lat_second_edge_valid", valid_out, 1);
        check("lat_second_edge_data", data_out, 1);
        step();
        valid_in0 = 1'b0;
        repeat (5) step();
        check("single_count", log_d.size(), 3);
        for (int i = 0; i < 3 && i < log_d.size(); i++) begin
            check($sformatf("single_data%0d", i), log_d[i], i + 1);
            check($sformatf("single_sel%0d", i), log_s[i], 0);
        end

        // Burst fairness, MAX_BURST=2
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
        ready_in = 1'b0;
        log_d.delete(); log_s.delete();
        for (int i = 0; i < 4; i++) begin
            valid_in0 = 1'b1; data_in0 = DW'(i);
            valid_in1 = 1'b1; data_in1 = DW'(8 + i);
            step();
        end
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        step();
        ready_in = 1'b1;
        repeat (10) step();
        exp_d = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h2, 4'h3, 4'hA, 4'hB};
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        check("fair_count", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            check($sformatf("fair_data%0d", i), log_d[i], exp_d[i]);
            check($sformatf("fair_sel%0d", i), log_s[i], exp_s[i]);
        end

        // Backpressure and full lane
        log_d.delete(); log_s.delete();
        ready_in = 1'b0;
        valid_in0 = 1'b1; data_in0 = 4'h7;
        step();
        valid_in0 = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            valid_in0 = 1'b1; data_in0 = DW'(8 + i);
            valid_in1 = 1'b1; data_in1 = DW'(1 + i);
            step();
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), valid_out, 1);
            check($sformatf("bp_data%0d", i), data_out, 7);
            check($sformatf("bp_sel%0d", i), selector, 0);
        end
        valid_in0 = 1'b0;
        data_in1 = 4'h4;
        step();
        @(negedge clk);
        check("full_ready_out1", ready_out1, 0);
        data_in1 = 4'hF;
        step();
        @(negedge clk);
        check("full_ready_out1_hold", ready_out1, 0);
        check("full_data_hold", data_out, 7);
        step();
        valid_in1 = 1'b0;
        ready_in = 1'b1;
        repeat (12) step();
        check("drain_count", log_d.size(), 8);
        n1 = 0;
        for (int i = 0; i < log_d.size(); i++) begin
            if (log_s[i]) begin
                n1++;
                check($sformatf("drain_lane1_word%0d", n1), log_d[i], n1);
            end
        end
        check("drain_lane1_words", n1, 4);

        // Reset mid-operation
        ready_in = 1'b0;
        valid_in0 = 1'b1; data_in0 = 4'h5;
        valid_in1 = 1'b1; data_in1 = 4'h6;
        step();
        step();
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        @(negedge clk);
        check("mid_valid_before", valid_out, 1);
        check("mid_data_before", data_out, 5);
        step();
        #1 reset_L = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_sel", selector, 0);
        check("mid_rst_ready0", ready_out0, 1);
        step();
        reset_L = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_valid", valid_out, 0);
        step();
        valid_in1 = 1'b1; data_in1 = 4'hC;
        step();
        valid_in1 = 1'b0;
        step();
        @(negedge clk);
        check("post_rst_new_valid", valid_out, 1);
        check("post_rst_new_data", data_out, 4'hC);
        check("post_rst_new_sel", selector, 1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
